// File: rtl/ex_mem_cond_stage_pkg.sv
// pipe_pkg: shared types for the execute/memory boundary.
//   cond_t      - ARM-style 4-bit condition codes
//   FLAG_*      - bit positions of N,Z,C,V inside a {N,Z,C,V} flag vector
//   em_ctrl_t   - control bundle carried from E into the M stage
package pipe_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       valid;
    logic       pcSrc;
    logic       regWrite;
    logic       memWrite;
    logic       memtoReg;
    logic [3:0] wa3;
  } em_ctrl_t;

endpackage

// File: rtl/ex_mem_cond_stage_if.sv
// ex_mem_if: E-stage bundle into the conditional-execute stage and the
// registered M-stage bundle out of it.
//   master : drives the E-stage signals, observes condition/M outputs
//   slave  : the stage itself (consumes E, produces condExE/pcSrcTakenE/M)
interface ex_mem_if #(
  parameter int WIDTH = 32
);
  // E stage
  logic             validE;
  logic [3:0]       condE;
  logic [1:0]       flagWriteE;
  logic [3:0]       aluFlagsE;
  logic             pcSrcE;
  logic             branchE;
  logic             regWriteE;
  logic             memWriteE;
  logic             memtoRegE;
  logic [3:0]       wa3E;
  logic [WIDTH-1:0] aluResultE;
  logic [WIDTH-1:0] writeDataE;
  // combinational condition results
  logic             condExE;
  logic             pcSrcTakenE;
  // M stage
  logic             validM;
  logic             pcSrcM;
  logic             regWriteM;
  logic             memWriteM;
  logic             memtoRegM;
  logic [3:0]       wa3M;
  logic [WIDTH-1:0] aluResultM;
  logic [WIDTH-1:0] writeDataM;
  logic [3:0]       flagsM;

  modport master (
    output validE, condE, flagWriteE, aluFlagsE, pcSrcE, branchE,
           regWriteE, memWriteE, memtoRegE, wa3E, aluResultE, writeDataE,
    input  condExE, pcSrcTakenE, validM, pcSrcM, regWriteM, memWriteM,
           memtoRegM, wa3M, aluResultM, writeDataM, flagsM
  );

  modport slave (
    input  validE, condE, flagWriteE, aluFlagsE, pcSrcE, branchE,
           regWriteE, memWriteE, memtoRegE, wa3E, aluResultE, writeDataE,
    output condExE, pcSrcTakenE, validM, pcSrcM, regWriteM, memWriteM,
           memtoRegM, wa3M, aluResultM, writeDataM, flagsM
  );

endinterface

// File: rtl/ex_mem_cond_stage_cond_check.sv
// cond_check: evaluates an ARM-style condition field against NZCV flags.
//   condE    in  4  condition field
//   flags    in  4  {N,Z,C,V}
//   condPass out 1  condition holds (1111 never passes)
module cond_check
  import pipe_pkg::*;
(
  input  logic [3:0] condE,
  input  logic [3:0] flags,
  output logic       condPass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    condPass = 1'b0;
    case (cond_t'(condE))
      COND_EQ: condPass = z;
      COND_NE: condPass = !z;
      COND_CS: condPass = c;
      COND_CC: condPass = !c;
      COND_MI: condPass = n;
      COND_PL: condPass = !n;
      COND_VS: condPass = v;
      COND_VC: condPass = !v;
      COND_HI: condPass = c && !z;
      COND_LS: condPass = !c || z;
      COND_GE: condPass = (n == v);
      COND_LT: condPass = (n != v);
      COND_GT: condPass = !z && (n == v);
      COND_LE: condPass = z || (n != v);
      COND_AL: condPass = 1'b1;
      default: condPass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_cond_stage.sv
// ex_mem_cond_stage: resolves conditional execution of the E-stage
// instruction against the architectural NZCV register, owns that register,
// and registers the gated bundle into the M stage.
//   clk    in  rising-edge clock
//   reset  in  asynchronous, active-low reset
//   stallM in  hold M register and flags
//   flushM in  load a bubble into M (wins over stallM)
//   bus    ex_mem_if.slave: E-stage inputs, condExE/pcSrcTakenE, M outputs
module ex_mem_cond_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     stallM,
  input  logic     flushM,
  ex_mem_if.slave  bus
);

  logic             cond_pass;
  logic             cond_ex;

  em_ctrl_t         ctrl_q, ctrl_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       flags_q, flags_d;

  // Condition is checked against the registered flags, i.e. flags written
  // by older instructions; a flag write lands in time for the next one.
  cond_check u_cond_check (
    .condE    (bus.condE),
    .flags    (flags_q),
    .condPass (cond_pass)
  );

  assign cond_ex          = cond_pass & bus.validE;
  assign bus.condExE      = cond_ex;
  assign bus.pcSrcTakenE  = (bus.pcSrcE | bus.branchE) & cond_ex;

  always_comb begin
    ctrl_d  = ctrl_q;
    alu_d   = alu_q;
    wdata_d = wdata_q;
    flags_d = flags_q;

    if (flushM) begin
      ctrl_d  = '0;
      alu_d   = '0;
      wdata_d = '0;
    end else if (!stallM) begin
      ctrl_d.valid    = bus.validE;
      ctrl_d.pcSrc    = (bus.pcSrcE | bus.branchE) & cond_ex;
      ctrl_d.regWrite = bus.regWriteE & cond_ex;
      ctrl_d.memWrite = bus.memWriteE & cond_ex;
      // memtoReg is not condition-gated, but a non-instruction must not
      // carry any live control into M.
      ctrl_d.memtoReg = bus.memtoRegE & bus.validE;
      ctrl_d.wa3      = bus.wa3E;
      alu_d           = bus.aluResultE;
      wdata_d         = bus.writeDataE;
    end

    if (cond_ex && !stallM && !flushM) begin
      if (bus.flagWriteE[1]) begin
        flags_d[FLAG_N] = bus.aluFlagsE[FLAG_N];
        flags_d[FLAG_Z] = bus.aluFlagsE[FLAG_Z];
      end
      if (bus.flagWriteE[0]) begin
        flags_d[FLAG_C] = bus.aluFlagsE[FLAG_C];
        flags_d[FLAG_V] = bus.aluFlagsE[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      alu_q   <= '0;
      wdata_q <= '0;
      flags_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
      flags_q <= flags_d;
    end
  end

  assign bus.validM     = ctrl_q.valid;
  assign bus.pcSrcM     = ctrl_q.pcSrc;
  assign bus.regWriteM  = ctrl_q.regWrite;
  assign bus.memWriteM  = ctrl_q.memWrite;
  assign bus.memtoRegM  = ctrl_q.memtoReg;
  assign bus.wa3M       = ctrl_q.wa3;
  assign bus.aluResultM = alu_q;
  assign bus.writeDataM = wdata_q;
  assign bus.flagsM     = flags_q;

endmodule

// File: tb/tb_ex_mem_cond_stage.sv
module tb_ex_mem_cond_stage;

  typedef struct packed {
    logic        valid;
    logic        pcSrc;
    logic        regWrite;
    logic        memWrite;
    logic        memtoReg;
    logic [3:0]  wa3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [3:0]  flags;
  } m_t;

  logic clk;
  logic reset;
  logic stallM;
  logic flushM;

  int passed = 0;
  int total  = 0;
  m_t sb[$];

  ex_mem_if #(.WIDTH(32)) bus ();

  ex_mem_cond_stage #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .stallM (stallM),
    .flushM (flushM),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic m_t mexp(input logic v, pcs, rw, mw, m2r, input logic [3:0] wa3,
                              input logic [31:0] alu, wd, input logic [3:0] fl);
    m_t e;
    e.valid = v; e.pcSrc = pcs; e.regWrite = rw; e.memWrite = mw; e.memtoReg = m2r;
    e.wa3 = wa3; e.alu = alu; e.wd = wd; e.flags = fl;
    return e;
  endfunction

  task automatic chk_m(input string tag, input m_t e);
    chk({tag, ".validM"},     bus.validM,     e.valid);
    chk({tag, ".pcSrcM"},     bus.pcSrcM,     e.pcSrc);
    chk({tag, ".regWriteM"},  bus.regWriteM,  e.regWrite);
    chk({tag, ".memWriteM"},  bus.memWriteM,  e.memWrite);
    chk({tag, ".memtoRegM"},  bus.memtoRegM,  e.memtoReg);
    chk({tag, ".wa3M"},       bus.wa3M,       e.wa3);
    chk({tag, ".aluResultM"}, bus.aluResultM, e.alu);
    chk({tag, ".writeDataM"}, bus.writeDataM, e.wd);
    chk({tag, ".flagsM"},     bus.flagsM,     e.flags);
  endtask

  task automatic drive(input logic [3:0] cond, input logic valid, input logic [1:0] fw,
                       input logic [3:0] af, input logic pcs, br, rw, mw, m2r,
                       input logic [3:0] wa3, input logic [31:0] alu, wd);
    bus.condE = cond; bus.validE = valid; bus.flagWriteE = fw; bus.aluFlagsE = af;
    bus.pcSrcE = pcs; bus.branchE = br; bus.regWriteE = rw; bus.memWriteE = mw;
    bus.memtoRegE = m2r; bus.wa3E = wa3; bus.aluResultE = alu; bus.writeDataE = wd;
  endtask

  // Called at a negedge with inputs already driven: checks the combinational
  // outputs, queues the expected M bundle, clocks once and checks it.
  task automatic step(input string tag, input logic exp_cx, exp_tk, input m_t e);
    m_t got;
    #1;
    chk({tag, ".condExE"},     bus.condExE,     exp_cx);
    chk({tag, ".pcSrcTakenE"}, bus.pcSrcTakenE, exp_tk);
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk_m(tag, got);
    $display("step %s: validM=%b regW=%b memW=%b pcSrc=%b wa3=%h alu=%h flags=%b",
             tag, bus.validM, bus.regWriteM, bus.memWriteM, bus.pcSrcM,
             bus.wa3M, bus.aluResultM, bus.flagsM);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; stallM = 1'b0; flushM = 1'b0;
    drive(4'hE, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_m("reset", mexp(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'b0000));
    reset = 1'b1;

    // AL load
    drive(4'hE, 1, 2'b00, 4'h0, 0, 0, 1, 0, 0, 4'h5, 32'h0000_00FF, 32'h0);
    step("al_load", 1, 0, mexp(1, 0, 1, 0, 0, 4'h5, 32'hFF, 32'h0, 4'b0000));

    // Full flag write, then EQ passes and NE fails on the new flags
    drive(4'hE, 1, 2'b11, 4'b0100, 0, 0, 0, 0, 0, 4'h1, 32'h11, 32'h0);
    step("flag_wr", 1, 0, mexp(1, 0, 0, 0, 0, 4'h1, 32'h11, 32'h0, 4'b0100));
    drive(4'h0, 1, 2'b00, 4'h0, 0, 0, 0, 1, 0, 4'h2, 32'h22, 32'h2222);
    step("eq_pass", 1, 0, mexp(1, 0, 0, 1, 0, 4'h2, 32'h22, 32'h2222, 4'b0100));
    drive(4'h1, 1, 2'b00, 4'h0, 0, 0, 0, 1, 0, 4'h3, 32'h33, 32'h3333);
    step("ne_fail", 0, 0, mexp(1, 0, 0, 0, 0, 4'h3, 32'h33, 32'h3333, 4'b0100));

    // Partial flag write: only C,V
    drive(4'hE, 1, 2'b01, 4'b1011, 0, 0, 0, 0, 0, 4'h4, 32'h44, 32'h0);
    step("part_wr", 1, 0, mexp(1, 0, 0, 0, 0, 4'h4, 32'h44, 32'h0, 4'b0111));

    // HI fails (Z=1): flag write suppressed, regWrite gated
    drive(4'h8, 1, 2'b11, 4'b0000, 0, 0, 1, 0, 0, 4'h6, 32'h66, 32'h0);
    step("hi_fail", 0, 0, mexp(1, 0, 0, 0, 0, 4'h6, 32'h66, 32'h0, 4'b0111));

    // LT passes (N=0, V=1)
    drive(4'hB, 1, 2'b00, 4'h0, 0, 0, 1, 0, 1, 4'hA, 32'hAA, 32'h0);
    step("lt_pass", 1, 0, mexp(1, 0, 1, 0, 1, 4'hA, 32'hAA, 32'h0, 4'b0111));

    // Invalid E with every control set
    drive(4'hE, 0, 2'b11, 4'b1111, 1, 1, 1, 1, 1, 4'h3, 32'h123, 32'h456);
    step("invalid", 0, 0, mexp(0, 0, 0, 0, 0, 4'h3, 32'h123, 32'h456, 4'b0111));

    // Stall holds M and flags
    drive(4'hE, 1, 2'b00, 4'h0, 0, 0, 1, 0, 0, 4'h9, 32'hDEAD_BEEF, 32'h0);
    step("ld_beef", 1, 0, mexp(1, 0, 1, 0, 0, 4'h9, 32'hDEAD_BEEF, 32'h0, 4'b0111));
    stallM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'hE, 1, 2'b11, 4'b1000, 0, 0, 0, 1, 0, 4'(i), 32'(i + 1), 32'(i + 7));
      step($sformatf("stall%0d", i), 1, 0,
           mexp(1, 0, 1, 0, 0, 4'h9, 32'hDEAD_BEEF, 32'h0, 4'b0111));
    end
    // Flush wins over stall
    flushM = 1'b1;
    drive(4'hE, 1, 2'b11, 4'b1000, 1, 0, 1, 1, 1, 4'hF, 32'h5555, 32'h6666);
    step("stl_fls", 1, 1, mexp(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'b0111));
    stallM = 1'b0; flushM = 1'b0;

    // Branch: clear flags, GT taken, then reserved cond never taken
    drive(4'hE, 1, 2'b11, 4'b0000, 0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    step("clr_flg", 1, 0, mexp(1, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'b0000));
    drive(4'hC, 1, 2'b00, 4'h0, 0, 1, 0, 0, 0, 4'hF, 32'h100, 32'h0);
    step("gt_br", 1, 1, mexp(1, 1, 0, 0, 0, 4'hF, 32'h100, 32'h0, 4'b0000));
    drive(4'hF, 1, 2'b11, 4'b1111, 0, 1, 0, 0, 0, 4'hF, 32'h200, 32'h0);
    step("nv_br", 0, 0, mexp(1, 0, 0, 0, 0, 4'hF, 32'h200, 32'h0, 4'b0000));

    // Async reset mid-cycle
    drive(4'hE, 1, 2'b11, 4'b1111, 0, 0, 1, 0, 0, 4'h8, 32'h888, 32'h999);
    step("set_all", 1, 0, mexp(1, 0, 1, 0, 0, 4'h8, 32'h888, 32'h999, 4'b1111));
    #2 reset = 1'b0;
    #1;
    chk_m("async_rst", mexp(0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0, 4'b0000));
    $display("async reset: validM=%b flagsM=%b", bus.validM, bus.flagsM);
    @(negedge clk);
    reset = 1'b1;
    drive(4'hE, 1, 2'b00, 4'h0, 0, 0, 1, 0, 0, 4'h7, 32'h77, 32'h0);
    step("post_rst", 1, 0, mexp(1, 0, 1, 0, 0, 4'h7, 32'h77, 32'h0, 4'b0000));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
